// File: rtl/pp_gen_8.sv
// pp_gen_8 -- partial-product generator feeding carry_save_8.
//
// Accepts one 32-bit operand pair plus element width through a valid/ready
// handshake, forms the 8x8 unsigned byte partial products with eight
// multipliers and presents them as one beat (sew 8/16) or two beats (sew 32)
// in the lane order carry_save_8 consumes.
//
// Notation: Ai = op_a[8i+7:8i], Bj = op_b[8j+7:8j], PP[k] = A(k%4)*B(k/4).
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid, in_ready     operand handshake
//   op_a, op_b             32-bit multiplicand / multiplier
//   sew_in                 element width: 00=8b, 01=16b, 10=32b, 11=reserved
//   start                  mult_out_* carry a valid beat
//   sew                    sew of the operation in flight (held when idle)
//   beat                   0=first beat, 1=second beat
//   last                   current beat is the final beat of the operation
//   mult_out_1..mult_out_8 16-bit partial products
//
// Optional feature (macro PP_OUT_REG_EN): adds one register stage on every
// output, making the output latency accept+2. in_ready is unaffected.

module pp_gen_8 #(
  parameter int NUM_MUL = 8,
  parameter int PP_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            op_a,
  input  logic [31:0]            op_b,
  input  logic [1:0]             sew_in,
  output logic                   start,
  output logic [1:0]             sew,
  output logic                   beat,
  output logic                   last,
  output logic signed [PP_W-1:0] mult_out_1,
  output logic signed [PP_W-1:0] mult_out_2,
  output logic signed [PP_W-1:0] mult_out_3,
  output logic signed [PP_W-1:0] mult_out_4,
  output logic signed [PP_W-1:0] mult_out_5,
  output logic signed [PP_W-1:0] mult_out_6,
  output logic signed [PP_W-1:0] mult_out_7,
  output logic signed [PP_W-1:0] mult_out_8
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;

  logic [1:0]      state;
  logic [31:0]     op_a_q;
  logic [31:0]     op_b_q;
  logic [1:0]      sew_r;
  logic            start_r;
  logic            beat_r;
  logic            last_r;
  logic [PP_W-1:0] mult_r [NUM_MUL];

  logic            accept;
  logic [31:0]     src_a;
  logic [31:0]     src_b;
  logic [1:0]      src_sew;
  logic            second;
  logic [1:0]      a_sel   [NUM_MUL];
  logic [1:0]      b_sel   [NUM_MUL];
  logic            lane_en [NUM_MUL];
  logic [PP_W-1:0] prod    [NUM_MUL];

  // A sew=32 operation blocks new input only while its first beat is out,
  // so back-to-back operations flow without a bubble.
  assign in_ready = (state == IDLE) || (state == BEAT1) ||
                    ((state == BEAT0) && (sew_r != SEW_32));
  assign accept   = in_valid && in_ready;

  // The multipliers are shared: on accept they see the live operands (beat 0
  // is registered on the accepting edge); otherwise they see the latched
  // operands, which is only used for the second beat of a sew=32 op.
  assign src_a   = accept ? op_a   : op_a_q;
  assign src_b   = accept ? op_b   : op_b_q;
  assign src_sew = accept ? sew_in : sew_r;
  assign second  = !accept;

  // Byte selection per lane.
  always_comb begin
    for (int k = 0; k < NUM_MUL; k++) begin
      a_sel[k]   = 2'd0;
      b_sel[k]   = 2'd0;
      lane_en[k] = 1'b0;
      case (src_sew)
        SEW_32: begin
          a_sel[k]   = 2'(k % 4);
          b_sel[k]   = 2'(k / 4) + (second ? 2'd2 : 2'd0);
          lane_en[k] = 1'b1;
        end
        SEW_16: begin
          // Lanes 0-3 cover element 0 (A0,A1 x B0,B1), lanes 4-7 element 1.
          a_sel[k]   = {k[2], k[0]};
          b_sel[k]   = {k[2], k[1]};
          lane_en[k] = 1'b1;
        end
        SEW_8: begin
          a_sel[k]   = 2'(k % 4);
          b_sel[k]   = 2'(k % 4);
          lane_en[k] = (k < 4);
        end
        default: begin
          lane_en[k] = 1'b0;
        end
      endcase
    end
  end

  // The eight 8x8 unsigned multipliers.
  always_comb begin
    for (int k = 0; k < NUM_MUL; k++) begin
      prod[k] = '0;
      if (lane_en[k]) begin
        prod[k] = PP_W'({8'd0, src_a[8*a_sel[k] +: 8]} *
                        {8'd0, src_b[8*b_sel[k] +: 8]});
      end
    end
  end

  // Sequencer and beat registers. The sew output holds between operations.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sew_r   <= SEW_8;
      start_r <= 1'b0;
      beat_r  <= 1'b0;
      last_r  <= 1'b0;
      for (int k = 0; k < NUM_MUL; k++) mult_r[k] <= '0;
    end else if (accept) begin
      state   <= BEAT0;
      op_a_q  <= op_a;
      op_b_q  <= op_b;
      sew_r   <= sew_in;
      start_r <= 1'b1;
      beat_r  <= 1'b0;
      last_r  <= (sew_in != SEW_32);
      for (int k = 0; k < NUM_MUL; k++) mult_r[k] <= prod[k];
    end else if ((state == BEAT0) && (sew_r == SEW_32)) begin
      state   <= BEAT1;
      start_r <= 1'b1;
      beat_r  <= 1'b1;
      last_r  <= 1'b1;
      for (int k = 0; k < NUM_MUL; k++) mult_r[k] <= prod[k];
    end else begin
      state   <= IDLE;
      start_r <= 1'b0;
      beat_r  <= 1'b0;
      last_r  <= 1'b0;
      for (int k = 0; k < NUM_MUL; k++) mult_r[k] <= '0;
    end
  end

`ifdef PP_OUT_REG_EN
  logic            start_o;
  logic [1:0]      sew_o;
  logic            beat_o;
  logic            last_o;
  logic [PP_W-1:0] mult_o [NUM_MUL];

  // Extra output stage: same beat sequence, one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_o <= 1'b0;
      sew_o   <= 2'b00;
      beat_o  <= 1'b0;
      last_o  <= 1'b0;
      for (int k = 0; k < NUM_MUL; k++) mult_o[k] <= '0;
    end else begin
      start_o <= start_r;
      sew_o   <= sew_r;
      beat_o  <= beat_r;
      last_o  <= last_r;
      for (int k = 0; k < NUM_MUL; k++) mult_o[k] <= mult_r[k];
    end
  end

  assign start      = start_o;
  assign sew        = sew_o;
  assign beat       = beat_o;
  assign last       = last_o;
  assign mult_out_1 = mult_o[0];
  assign mult_out_2 = mult_o[1];
  assign mult_out_3 = mult_o[2];
  assign mult_out_4 = mult_o[3];
  assign mult_out_5 = mult_o[4];
  assign mult_out_6 = mult_o[5];
  assign mult_out_7 = mult_o[6];
  assign mult_out_8 = mult_o[7];
`else
  assign start      = start_r;
  assign sew        = sew_r;
  assign beat       = beat_r;
  assign last       = last_r;
  assign mult_out_1 = mult_r[0];
  assign mult_out_2 = mult_r[1];
  assign mult_out_3 = mult_r[2];
  assign mult_out_4 = mult_r[3];
  assign mult_out_5 = mult_r[4];
  assign mult_out_6 = mult_r[5];
  assign mult_out_7 = mult_r[6];
  assign mult_out_8 = mult_r[7];
`endif

endmodule

// File: tb/tb_pp_gen_8.sv
// tb_pp_gen_8 -- directed testbench for pp_gen_8 (default build, output
// latency accept+1). Inputs are driven and outputs sampled on the falling
// clock edge; expected values are hand-computed constants.

module tb_pp_gen_8;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  sew_in;
  logic        start;
  logic [1:0]  sew;
  logic        beat;
  logic        last;
  logic signed [15:0] mult_out_1, mult_out_2, mult_out_3, mult_out_4;
  logic signed [15:0] mult_out_5, mult_out_6, mult_out_7, mult_out_8;

  int checks;
  int fails;

  logic [127:0] bundle;
  logic [63:0]  acc;

  pp_gen_8 dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .sew_in     (sew_in),
    .start      (start),
    .sew        (sew),
    .beat       (beat),
    .last       (last),
    .mult_out_1 (mult_out_1),
    .mult_out_2 (mult_out_2),
    .mult_out_3 (mult_out_3),
    .mult_out_4 (mult_out_4),
    .mult_out_5 (mult_out_5),
    .mult_out_6 (mult_out_6),
    .mult_out_7 (mult_out_7),
    .mult_out_8 (mult_out_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bundle = {mult_out_1, mult_out_2, mult_out_3, mult_out_4,
                   mult_out_5, mult_out_6, mult_out_7, mult_out_8};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a,
                               input logic [31:0] b, input logic [1:0] s);
    in_valid = v;
    op_a     = a;
    op_b     = b;
    sew_in   = s;
  endtask

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_start,
                             input logic [1:0] exp_sew, input logic exp_beat,
                             input logic exp_last, input logic [127:0] exp_mult,
                             input logic exp_ready);
    check({tag, ".start"}, 128'(start), 128'(exp_start));
    check({tag, ".sew"},   128'(sew),   128'(exp_sew));
    check({tag, ".beat"},  128'(beat),  128'(exp_beat));
    check({tag, ".last"},  128'(last),  128'(exp_last));
    check({tag, ".mult"},  bundle,      exp_mult);
    check({tag, ".ready"}, 128'(in_ready), 128'(exp_ready));
  endtask

  // Downstream weighting of the sew=32 partial products: lane k of beat b
  // carries A(k%4)*B(k/4 + 2b), weighted by 2^(8*(k%4 + k/4 + 2b)).
  task automatic accumulate(input int b);
    for (int k = 0; k < 8; k++) begin
      acc = acc + (64'(bundle[127-16*k -: 16]) << (8 * (k % 4 + k / 4 + 2 * b)));
    end
  endtask

  localparam logic [127:0] ALL_FE01 = {8{16'hFE01}};
  localparam logic [127:0] ZERO     = 128'd0;
  localparam logic [127:0] EXP_S8   = {16'h0005, 16'h000C, 16'h0015, 16'h0020,
                                       64'd0};
  localparam logic [127:0] EXP_S16  = {16'h0005, 16'h000A, 16'h0006, 16'h000C,
                                       16'h0015, 16'h001C, 16'h0018, 16'h0020};

  initial begin
    checks = 0;
    fails  = 0;
    acc    = '0;
    reset  = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b00);
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset", 1'b0, 2'b00, 1'b0, 1'b0, ZERO, 1'b1);

    // sew=32, all ones; operands scrambled after accept.
    $display("[TB] sew=32 all-ones");
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10);
    tick();
    applyStimulus(1'b0, 32'h12345678, 32'h9ABCDEF0, 2'b00);
    checkOutput("s32.b0", 1'b1, 2'b10, 1'b0, 1'b0, ALL_FE01, 1'b0);
    accumulate(0);
    tick();
    checkOutput("s32.b1", 1'b1, 2'b10, 1'b1, 1'b1, ALL_FE01, 1'b1);
    accumulate(1);
    check("s32.sum", 128'(acc), 128'(64'hFFFFFFFE00000001));
    tick();
    checkOutput("s32.idle", 1'b0, 2'b10, 1'b0, 1'b0, ZERO, 1'b1);

    // sew=8
    $display("[TB] sew=8");
    applyStimulus(1'b1, 32'h04030201, 32'h08070605, 2'b00);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b11);
    checkOutput("s8", 1'b1, 2'b00, 1'b0, 1'b1, EXP_S8, 1'b1);
    tick();
    checkOutput("s8.idle", 1'b0, 2'b00, 1'b0, 1'b0, ZERO, 1'b1);

    // sew=16
    $display("[TB] sew=16");
    applyStimulus(1'b1, 32'h04030201, 32'h08070605, 2'b01);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b00);
    checkOutput("s16", 1'b1, 2'b01, 1'b0, 1'b1, EXP_S16, 1'b1);
    tick();
    checkOutput("s16.idle", 1'b0, 2'b01, 1'b0, 1'b0, ZERO, 1'b1);

    // sew=11 reserved
    $display("[TB] sew=11 reserved");
    applyStimulus(1'b1, 32'h04030201, 32'h08070605, 2'b11);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b00);
    checkOutput("s11", 1'b1, 2'b11, 1'b0, 1'b1, ZERO, 1'b1);
    tick();
    checkOutput("s11.idle", 1'b0, 2'b11, 1'b0, 1'b0, ZERO, 1'b1);

    // Back-to-back: sew=8, sew=32, then sew=16 held valid.
    $display("[TB] back-to-back");
    applyStimulus(1'b1, 32'h04030201, 32'h08070605, 2'b00);
    tick();
    checkOutput("b2b.op1", 1'b1, 2'b00, 1'b0, 1'b1, EXP_S8, 1'b1);
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10);
    tick();
    checkOutput("b2b.op2b0", 1'b1, 2'b10, 1'b0, 1'b0, ALL_FE01, 1'b0);
    applyStimulus(1'b1, 32'h04030201, 32'h08070605, 2'b01);
    tick();
    checkOutput("b2b.op2b1", 1'b1, 2'b10, 1'b1, 1'b1, ALL_FE01, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b00);
    checkOutput("b2b.op3", 1'b1, 2'b01, 1'b0, 1'b1, EXP_S16, 1'b1);
    tick();
    checkOutput("b2b.idle", 1'b0, 2'b01, 1'b0, 1'b0, ZERO, 1'b1);

    // Reset during BEAT0 of a sew=32 op.
    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b00);
    checkOutput("rst.b0", 1'b1, 2'b10, 1'b0, 1'b0, ALL_FE01, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst.after", 1'b0, 2'b00, 1'b0, 1'b0, ZERO, 1'b1);
    tick();
    checkOutput("rst.nobeat1", 1'b0, 2'b00, 1'b0, 1'b0, ZERO, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
